// File: rtl/score_event_gen.sv
// Turns level-style collision flags into single-cycle hit/bonus pulses for the
// score digit counter, queueing bursts and spacing pulses so the carry settles.
//
// state   | meaning
// IDLE    | waiting; bonus queue checked before hit queue
// ISSUE_B | bonus + enable high this cycle, one bonus popped
// ISSUE_H | hit + enable high this cycle, one hit popped
// GAP     | forced quiet time of GAP_CYCLES clocks after a pulse
module score_event_gen #(
  parameter int MAX_PENDING = 7,
  parameter int CNT_W       = 3,
  parameter int GAP_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startOfFrame,
  input  logic             collisionHit,
  input  logic             collisionBonus,
  input  logic             gameOver,
  output logic             hit,
  output logic             bonus,
  output logic             enable,
  output logic [CNT_W-1:0] pendingHit,
  output logic [CNT_W-1:0] pendingBonus,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE_B = 2'd1,
    ISSUE_H = 2'd2,
    GAP     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PENDING);
  localparam logic [3:0]       GAP_LOAD = 4'(GAP_CYCLES);

  state_t     state;
  state_t     stateNext;
  logic [3:0] gapCnt;

  logic hitSeen;
  logic bonusSeen;
  logic prevHitSeen;
  logic prevBonusSeen;
  logic pushHit;
  logic pushBonus;
  logic popHit;
  logic popBonus;

  // Saturating queue update; a push at the limit is dropped rather than wrapping.
  function automatic logic [CNT_W-1:0] queueNext(
    input logic [CNT_W-1:0] cur,
    input logic             push,
    input logic             pop
  );
    logic [CNT_W-1:0] nxt;
    nxt = cur;
    if (push && !pop) begin
      if (cur < MAX_CNT) nxt = cur + 1'b1;
    end else if (pop && !push) begin
      if (cur != '0) nxt = cur - 1'b1;
    end
    return nxt;
  endfunction

  // A frame only produces an event when its collision was absent the frame before.
  assign pushHit   = startOfFrame & hitSeen & ~prevHitSeen;
  assign pushBonus = startOfFrame & bonusSeen & ~prevBonusSeen;
  assign popHit    = (state == ISSUE_H);
  assign popBonus  = (state == ISSUE_B);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hitSeen       <= 1'b0;
      bonusSeen     <= 1'b0;
      prevHitSeen   <= 1'b0;
      prevBonusSeen <= 1'b0;
    end else if (gameOver) begin
      hitSeen       <= 1'b0;
      bonusSeen     <= 1'b0;
      prevHitSeen   <= 1'b0;
      prevBonusSeen <= 1'b0;
    end else if (startOfFrame) begin
      prevHitSeen   <= hitSeen;
      prevBonusSeen <= bonusSeen;
      hitSeen       <= collisionHit;
      bonusSeen     <= collisionBonus;
    end else begin
      hitSeen       <= hitSeen | collisionHit;
      bonusSeen     <= bonusSeen | collisionBonus;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pendingHit   <= '0;
      pendingBonus <= '0;
    end else if (gameOver) begin
      pendingHit   <= '0;
      pendingBonus <= '0;
    end else begin
      pendingHit   <= queueNext(pendingHit, pushHit, popHit);
      pendingBonus <= queueNext(pendingBonus, pushBonus, popBonus);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (pendingBonus != '0)    stateNext = ISSUE_B;
        else if (pendingHit != '0) stateNext = ISSUE_H;
      end
      ISSUE_B: stateNext = GAP;
      ISSUE_H: stateNext = GAP;
      GAP: begin
        if (gapCnt <= 4'd1) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (gameOver) stateNext = IDLE;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      gapCnt <= '0;
    end else if (gameOver) begin
      gapCnt <= '0;
    end else if (state == ISSUE_B || state == ISSUE_H) begin
      gapCnt <= GAP_LOAD;
    end else if (state == GAP && gapCnt != '0) begin
      gapCnt <= gapCnt - 4'd1;
    end
  end

  // Pulses decode the registered state, so they are glitch-free and one cycle wide.
  always_comb begin
    hit    = 1'b0;
    bonus  = 1'b0;
    enable = 1'b0;
    case (state)
      ISSUE_B: begin
        bonus  = 1'b1;
        enable = 1'b1;
      end
      ISSUE_H: begin
        hit    = 1'b1;
        enable = 1'b1;
      end
      default: begin
        hit    = 1'b0;
        bonus  = 1'b0;
        enable = 1'b0;
      end
    endcase
  end

  assign busy = (state != IDLE) || (pendingHit != '0) || (pendingBonus != '0);

endmodule

// File: tb/tb_score_event_gen.sv
// Scoreboard bench for score_event_gen: directed frames push expected pulses,
// a negedge monitor pops and compares kind and cycle of every pulse.
module tb_score_event_gen;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic resetN;
  logic startOfFrame, collisionHit, collisionBonus, gameOver;
  logic hit, bonus, enable, busy;
  logic [CNT_W-1:0] pendingHit, pendingBonus;

  logic sof2, cH2, cB2, go2;
  logic hit2, bonus2, enable2, busy2;
  logic [CNT_W-1:0] pH2, pB2;

  score_event_gen #(.MAX_PENDING(7), .CNT_W(CNT_W), .GAP_CYCLES(2)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .collisionHit(collisionHit), .collisionBonus(collisionBonus), .gameOver(gameOver),
    .hit(hit), .bonus(bonus), .enable(enable),
    .pendingHit(pendingHit), .pendingBonus(pendingBonus), .busy(busy)
  );

  score_event_gen #(.MAX_PENDING(7), .CNT_W(CNT_W), .GAP_CYCLES(15)) dut15 (
    .clk(clk), .resetN(resetN), .startOfFrame(sof2),
    .collisionHit(cH2), .collisionBonus(cB2), .gameOver(go2),
    .hit(hit2), .bonus(bonus2), .enable(enable2),
    .pendingHit(pH2), .pendingBonus(pB2), .busy(busy2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit isBonus;
    int at;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_pulse(input bit isBonus, input int at);
    exp_t x;
    x.isBonus = isBonus;
    x.at      = at;
    sb.push_back(x);
  endtask

  // Monitor for the main instance.
  logic prevPulse = 1'b0;
  always @(negedge clk) begin
    if (!resetN) begin
      prevPulse = 1'b0;
    end else begin
      check("enable_pairing", enable, hit | bonus);
      if (hit | bonus) begin
        check("hit_bonus_exclusive", hit & bonus, 0);
        check("no_back_to_back", prevPulse, 0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse actual hit=%0d bonus=%0d expected none (cycle %0d)",
                   hit, bonus, cyc);
        end else begin
          e = sb.pop_front();
          check("pulse_kind_bonus", bonus, e.isBonus);
          check("pulse_cycle", cyc, e.at);
        end
      end
      prevPulse = hit | bonus;
    end
  end

  // Observer for the long-gap instance.
  int hitCnt2 = 0, bonusCnt2 = 0, maxPB2 = 0;
  bit wrap2 = 1'b0;
  logic [CNT_W-1:0] prevPB2 = '0;
  always @(negedge clk) begin
    if (resetN) begin
      if (hit2) hitCnt2++;
      if (bonus2) bonusCnt2++;
      if (int'(pB2) > maxPB2) maxPB2 = int'(pB2);
      if (prevPB2 == 3'd7 && pB2 == 3'd0) wrap2 = 1'b1;
      prevPB2 = pB2;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [CNT_W-1:0] ph1, pb1, ph3;
  logic [7:0] rstOut;

  // One frame: startOfFrame cycle, then collisions for the first nh/nb body cycles.
  task automatic frame(input int len, input int nh, input int nb, input int rstAt);
    startOfFrame   = 1'b1;
    collisionHit   = 1'b0;
    collisionBonus = 1'b0;
    tick();
    startOfFrame = 1'b0;
    for (int i = 1; i < len; i++) begin
      collisionHit   = (i <= nh);
      collisionBonus = (i <= nb);
      if (i == 1) begin
        ph1 = pendingHit;
        pb1 = pendingBonus;
      end
      if (i == 3) ph3 = pendingHit;
      if (i == rstAt) begin
        resetN = 1'b0;
        #1;
        rstOut = {hit, bonus, enable, busy, 1'b0, pendingHit};
      end
      if (i == rstAt + 3) resetN = 1'b1;
      tick();
    end
    collisionHit   = 1'b0;
    collisionBonus = 1'b0;
  endtask

  int s, a;

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; collisionHit = 1'b0; collisionBonus = 1'b0;
    gameOver = 1'b0; sof2 = 1'b0; cH2 = 1'b0; cB2 = 1'b0; go2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hit", hit, 0);
    check("rst_bonus", bonus, 0);
    check("rst_enable", enable, 0);
    check("rst_busy", busy, 0);
    check("rst_pendingHit", pendingHit, 0);
    check("rst_pendingBonus", pendingBonus, 0);
    resetN = 1'b1;
    tick(); tick();

    // Single collision inside frame 1, long frames.
    frame(100, 40, 0, -1);
    s = cyc; expect_pulse(1'b0, s + 2);
    frame(100, 0, 0, -1);
    check("t1_pendHit_push", ph1, 1);
    check("t1_pendHit_pop", ph3, 0);

    // Collision across three frames, clear frame, then a fresh collision.
    frame(20, 10, 0, -1);
    s = cyc; expect_pulse(1'b0, s + 2);
    frame(20, 10, 0, -1);
    frame(20, 10, 0, -1);
    frame(20, 0, 0, -1);
    frame(20, 10, 0, -1);
    s = cyc; expect_pulse(1'b0, s + 2);
    frame(20, 0, 0, -1);

    // Hit and bonus in one frame: bonus first, hit GAP_CYCLES+2 later.
    frame(20, 10, 10, -1);
    s = cyc; expect_pulse(1'b1, s + 2); expect_pulse(1'b0, s + 6);
    frame(20, 0, 0, -1);
    check("t3_pendHit_push", ph1, 1);
    check("t3_pendBonus_push", pb1, 1);

    // One-cycle frames build a backlog of 3 hits, then gameOver clears it.
    startOfFrame = 1'b1;
    tick(); tick();
    a = cyc;
    expect_pulse(1'b0, a + 3);
    expect_pulse(1'b0, a + 7);
    for (int k = 0; k < 10; k++) begin
      collisionHit = (k % 2 == 0);
      tick();
    end
    collisionHit = 1'b0;
    check("t4_pendHit_before_go", pendingHit, 3);
    gameOver = 1'b1; collisionHit = 1'b1; collisionBonus = 1'b1;
    tick();
    check("t4_pendHit_after_go", pendingHit, 0);
    check("t4_busy_after_go", busy, 0);
    tick(); tick();
    gameOver = 1'b0; collisionHit = 1'b0; collisionBonus = 1'b0;
    tick(); tick();
    startOfFrame = 1'b0;
    frame(20, 0, 0, -1);
    frame(20, 0, 0, -1);
    check("t4_pendHit_end", pendingHit, 0);
    check("t4_pendBonus_end", pendingBonus, 0);

    // Reset asserted during the gap after a pulse.
    frame(20, 10, 0, -1);
    s = cyc; expect_pulse(1'b0, s + 2);
    frame(20, 0, 0, 3);
    check("t5_rst_hit", rstOut[7], 0);
    check("t5_rst_bonus", rstOut[6], 0);
    check("t5_rst_enable", rstOut[5], 0);
    check("t5_rst_busy", rstOut[4], 0);
    check("t5_rst_pendingHit", rstOut[2:0], 0);
    frame(20, 0, 0, -1);
    frame(20, 10, 0, -1);
    s = cyc; expect_pulse(1'b0, s + 2);
    frame(20, 0, 0, -1);

    // Long gap: one hit in flight while 9 bonus events arrive; 2 are dropped.
    for (int t = 0; t < 160; t++) begin
      sof2 = 1'b1;
      cH2  = (t == 0);
      cB2  = (t % 2 == 1) && (t <= 17);
      tick();
    end
    sof2 = 1'b0; cH2 = 1'b0; cB2 = 1'b0;
    tick();
    check("sat_bonus_pulses", bonusCnt2, 7);
    check("sat_hit_pulses", hitCnt2, 1);
    check("sat_max_pendingBonus", maxPB2, 7);
    check("sat_no_wrap", wrap2, 0);
    check("sat_pendingBonus_end", pB2, 0);
    check("sat_busy_end", busy2, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
